// File: rtl/dependency_check_if.sv
// Decode/writeback handshake bundle for the register dependency scoreboard.
// The decode side drives the instruction and writeback fields; the scoreboard answers.
interface dependency_check_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  flushBack_i;
    logic                  enable_i;
    logic [REG_ADDR_W-1:0] primOperand_i;
    logic [15:0]           secOperand_i;
    logic                  pRead_i;
    logic                  pWrite_i;
    logic                  sRead_i;
    logic                  wbEnable_i;
    logic [REG_ADDR_W-1:0] wbReg_i;
    logic                  stall_o;
    logic                  issue_o;
    logic                  busy_o;
    logic                  underflow_o;

    modport master (
        output flushBack_i, enable_i, primOperand_i, secOperand_i,
        output pRead_i, pWrite_i, sRead_i, wbEnable_i, wbReg_i,
        input  stall_o, issue_o, busy_o, underflow_o
    );

    modport slave (
        input  flushBack_i, enable_i, primOperand_i, secOperand_i,
        input  pRead_i, pWrite_i, sRead_i, wbEnable_i, wbReg_i,
        output stall_o, issue_o, busy_o, underflow_o
    );
endinterface

// File: rtl/dependency_check.sv
// Register scoreboard between decode and execute: counts in-flight writes per
// register, stalls RAW hazards and counter saturation, retires on writeback.
module dependency_check #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PEND_W     = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    dependency_check_if.slave    bus
);
    localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;

    logic [PEND_W-1:0]     pend_q [NUM_REGS];
    logic [PEND_W-1:0]     pend_d [NUM_REGS];
    logic                  busy_q;
    logic                  busy_d;
    logic                  underflow_q;
    logic                  underflow_d;

    logic [REG_ADDR_W-1:0] prim;
    logic [REG_ADDR_W-1:0] sec;
    logic                  hazard_c;
    logic                  gate_c;
    logic                  inc_c;
    logic                  inc_hit;
    logic                  dec_hit;
    logic                  unused_sec;

    assign prim       = bus.primOperand_i;
    assign sec        = bus.secOperand_i[REG_ADDR_W-1:0];
    assign unused_sec = ^bus.secOperand_i[15:REG_ADDR_W];

    // Hazards look only at registered counters; a same-cycle writeback is not bypassed.
    always_comb begin
        hazard_c = 1'b0;
        if (bus.pRead_i && (pend_q[prim] != '0)) begin
            hazard_c = 1'b1;
        end
        if (bus.sRead_i && (pend_q[sec] != '0)) begin
            hazard_c = 1'b1;
        end
        if (bus.pWrite_i && (pend_q[prim] == PEND_W'(PEND_MAX))) begin
            hazard_c = 1'b1;
        end
    end

    // Reset and flush both kill the handshake in the cycle they are asserted.
    assign gate_c      = bus.enable_i && !bus.flushBack_i && !reset_i;
    assign bus.stall_o = gate_c && hazard_c;
    assign bus.issue_o = gate_c && !hazard_c;
    assign inc_c       = bus.issue_o && bus.pWrite_i;

    always_comb begin
        pend_d      = pend_q;
        underflow_d = underflow_q;
        busy_d      = 1'b0;
        inc_hit     = 1'b0;
        dec_hit     = 1'b0;
        if (bus.flushBack_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                pend_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                inc_hit = inc_c && (prim == REG_ADDR_W'(i));
                dec_hit = bus.wbEnable_i && (bus.wbReg_i == REG_ADDR_W'(i));
                // Issue and retire on the same register cancel out.
                if (inc_hit && !dec_hit) begin
                    pend_d[i] = pend_q[i] + PEND_W'(1);
                end else if (dec_hit && !inc_hit) begin
                    if (pend_q[i] == '0) begin
                        underflow_d = 1'b1;
                    end else begin
                        pend_d[i] = pend_q[i] - PEND_W'(1);
                    end
                end
            end
        end
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (pend_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                pend_q[i] <= '0;
            end
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.underflow_o = underflow_q;
endmodule
